// File: rtl/inst_loader_if.sv
// Stream and instruction-queue write-port bundle for inst_loader.
// The host drives the byte stream through the master modport. The loader
// (slave modport) returns rx_ready and drives the queue write port.
interface inst_loader_if #(
    parameter int AW = 6,
    parameter int IW = 39
);
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles a framed byte stream into 39-bit instructions and
// writes them into the nucore instruction queue. The core is held in reset
// while a load is in progress.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that is compared against the payload.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no load active; core runs; waits for start
// HEADER | waiting for the header byte (2'b10 tag, N-1 in bits 5:0)
// BYTES  | collecting the 5 little-endian bytes of one instruction
// WRITE  | one-cycle queue write of the assembled instruction
// CKSUM  | waiting for the checksum byte (checksum build only)
// DONE   | one-cycle completion pulse; core released
// ERROR  | framing error; core held; waits for start
module inst_loader #(
    parameter int DEPTH = 64,
    parameter int IW    = 39
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    inst_loader_if.slave               bus,
    output logic                       core_hold,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH):0]     loaded_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        BYTES  = 3'd2,
        WRITE  = 3'd3,
`ifdef INST_LOADER_CHECKSUM_EN
        CKSUM  = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    byte_idx_q;
    logic [CW-1:0] n_total_q;
    logic [CW-1:0] count_q;
    logic [IW-1:0] asm_q;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]    cksum_q;
`endif

    logic start_ok;
    assign start_ok = start && (state_q == IDLE || state_q == ERROR);

    // The instruction index and the written count always advance together,
    // so one register serves as both wr_addr and loaded_count.
    assign loaded_count = count_q;
    assign bus.wr_addr  = count_q[CW-2:0];
    assign bus.wr_data  = asm_q;

    // State register; reset drops core_hold asynchronously through the decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d      = state_q;
        bus.rx_ready = 1'b0;
        bus.wr_en    = 1'b0;
        core_hold    = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (state_q)
            IDLE: begin
                core_hold = 1'b0;
                if (start) state_d = HEADER;
            end
            HEADER: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid)
                    state_d = (bus.rx_data[7:6] == 2'b10) ? BYTES : ERROR;
            end
            BYTES: begin
                bus.rx_ready = 1'b1;
                // Byte 5 bit 7 is instruction bit 39, which must be zero.
                if (bus.rx_valid && byte_idx_q == 3'd4)
                    state_d = bus.rx_data[7] ? ERROR : WRITE;
            end
            WRITE: begin
                bus.wr_en = 1'b1;
                if ((count_q + CW'(1)) == n_total_q)
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = CKSUM;
`else
                    state_d = DONE;
`endif
                else
                    state_d = BYTES;
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CKSUM: begin
                bus.rx_ready = 1'b1;
                if (bus.rx_valid)
                    state_d = (bus.rx_data == cksum_q) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                state_d   = IDLE;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_d = HEADER;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: header length, byte assembly, instruction count, checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q <= 3'd0;
            n_total_q  <= '0;
            count_q    <= '0;
            asm_q      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            cksum_q    <= 8'd0;
`endif
        end else begin
            if (start_ok) begin
                byte_idx_q <= 3'd0;
                count_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                cksum_q    <= 8'd0;
`endif
            end
            case (state_q)
                HEADER: begin
                    if (bus.rx_valid)
                        n_total_q <= CW'(bus.rx_data[5:0]) + CW'(1);
                end
                BYTES: begin
                    if (bus.rx_valid) begin
                        case (byte_idx_q)
                            3'd0:    asm_q[7:0]   <= bus.rx_data;
                            3'd1:    asm_q[15:8]  <= bus.rx_data;
                            3'd2:    asm_q[23:16] <= bus.rx_data;
                            3'd3:    asm_q[31:24] <= bus.rx_data;
                            default: asm_q[IW-1:32] <= bus.rx_data[IW-33:0];
                        endcase
                        byte_idx_q <= (byte_idx_q == 3'd4) ? 3'd0 : byte_idx_q + 3'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                        cksum_q    <= cksum_q ^ bus.rx_data;
`endif
                    end
                end
                WRITE:   count_q <= count_q + CW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader. Writes to the queue and done pulses
// are logged on the falling edge; each test task checks its own results.
module tb_inst_loader;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       core_hold, done, error;
    logic [6:0] loaded_count;

    int checks = 0;
    int errors = 0;

    inst_loader_if bus ();

    inst_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;

    logic [5:0]  log_addr[$];
    logic [38:0] log_data[$];
    int          done_cnt = 0;
    logic [7:0]  tb_xor;

    // Log every queue write and done pulse seen during a clock cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_stall);
        int n;
        n = 0;
        @(negedge clk);
        if (max_stall > 0) repeat ($urandom_range(0, max_stall)) @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_byte: rx_ready never high, byte %h", b);
        end else begin
            @(posedge clk);
        end
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [39:0] w, input int max_stall);
        for (int k = 0; k < 5; k++) begin
            send_byte(w[k*8 +: 8], max_stall);
            tb_xor = tb_xor ^ w[k*8 +: 8];
        end
    endtask

    task automatic send_trailer();
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(tb_xor, 0);
`endif
    endtask

    task automatic expect_done(output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 50);
        cycles = n;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, n);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.wr_en, core_hold, done, error} !== 5'b0 ||
            bus.wr_addr !== 6'd0 || bus.wr_data !== 39'd0 || loaded_count !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b wr_en=%b hold=%b done=%b err=%b addr=%h data=%h cnt=%0d, want all 0",
                     bus.rx_ready, bus.wr_en, core_hold, done, error, bus.wr_addr, bus.wr_data, loaded_count);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc;
        log_addr.delete(); log_data.delete();
        pulse_start();
        checks++;
        if (bus.rx_ready !== 1'b1 || core_hold !== 1'b1 || loaded_count !== 7'd0) begin
            errors++;
            $display("FAIL start_latency: rdy=%b hold=%b cnt=%0d, want 1 1 0", bus.rx_ready, core_hold, loaded_count);
        end
        send_byte(8'h80, 0);
        send_word(40'h40_0000_0001, 0);
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 6'd0 || bus.wr_data !== 39'h40_0000_0001 || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_write: wr_en=%b addr=%h data=%h rdy=%b, want 1 00 4000000001 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.rx_ready);
        end
        send_trailer();
        expect_done(cyc);
        checks++;
        if (cyc != 1 || core_hold !== 1'b0 || loaded_count !== 7'd1) begin
            errors++;
            $display("FAIL single_done: cycles=%0d hold=%b cnt=%0d, want 1 0 1", cyc, core_hold, loaded_count);
        end
        @(negedge clk);
        checks++;
        if (log_addr.size() != 1 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_count: writes=%0d done=%b, want 1 0", log_addr.size(), done);
        end
    endtask

    task automatic test_full_load();
        int cyc;
        int bad;
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'hBF, 0);
        for (int i = 0; i < 64; i++) send_word(40'(i), 0);
        send_trailer();
        expect_done(cyc);
        repeat (4) @(negedge clk);
        checks++;
        if (log_addr.size() != 64 || loaded_count !== 7'd64) begin
            errors++;
            $display("FAIL full_count: writes=%0d cnt=%0d, want 64 64", log_addr.size(), loaded_count);
        end
        bad = 0;
        for (int i = 0; i < 64 && i < log_addr.size(); i++)
            if (log_addr[i] !== 6'(i) || log_data[i] !== 39'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_data: %0d entries with wrong addr/data, want 0", bad);
        end
    endtask

    task automatic test_bad_header();
        int cyc;
        int d0;
        log_addr.delete(); log_data.delete();
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h40, 0);
        @(negedge clk);
        checks++;
        if (error !== 1'b1 || core_hold !== 1'b1 || bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_header: err=%b hold=%b rdy=%b, want 1 1 0", error, core_hold, bus.rx_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (log_addr.size() != 0 || done_cnt != d0 || error !== 1'b1) begin
            errors++;
            $display("FAIL bad_header_quiet: writes=%0d dones=%0d err=%b, want 0 0 1",
                     log_addr.size(), done_cnt - d0, error);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: err=%b rdy=%b, want 0 1", error, bus.rx_ready);
        end
        send_byte(8'h80, 0);
        send_word(40'h00_0000_0007, 0);
        send_trailer();
        expect_done(cyc);
        checks++;
        if (log_data.size() != 1 || log_data[0] !== 39'h7 || error !== 1'b0) begin
            errors++;
            $display("FAIL recover_load: writes=%0d err=%b, want 1 write of 7 and err 0", log_data.size(), error);
        end
    endtask

    task automatic test_bit39();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h81, 0);
        send_word(40'h00_0000_0005, 0);
        send_word(40'h80_0000_0000, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1 || core_hold !== 1'b1 || loaded_count !== 7'd1) begin
            errors++;
            $display("FAIL bit39_error: err=%b hold=%b cnt=%0d, want 1 1 1", error, core_hold, loaded_count);
        end
        checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 6'd0 || log_data[0] !== 39'h5) begin
            errors++;
            $display("FAIL bit39_writes: writes=%0d, want 1 write of 5 at addr 0", log_addr.size());
        end
    endtask

    task automatic test_stall();
        int cyc;
        logic [39:0] words[4];
        int bad;
        words[0] = 40'h00_0000_0003;
        words[1] = 40'h7F_FFFF_FFFF;
        words[2] = 40'h12_3456_789A;
        words[3] = 40'h00_0000_0000;
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h83, 3);
        for (int i = 0; i < 4; i++) send_word(words[i], 3);
        send_trailer();
        expect_done(cyc);
        checks++;
        if (log_addr.size() != 4 || loaded_count !== 7'd4) begin
            errors++;
            $display("FAIL stall_count: writes=%0d cnt=%0d, want 4 4", log_addr.size(), loaded_count);
        end
        bad = 0;
        for (int i = 0; i < 4 && i < log_addr.size(); i++)
            if (log_addr[i] !== 6'(i) || log_data[i] !== words[i][38:0]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_data: %0d wrong entries, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h80, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rx_ready, bus.wr_en, core_hold, done, error} !== 5'b0 ||
            bus.wr_addr !== 6'd0 || bus.wr_data !== 39'd0 || loaded_count !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_load: rdy=%b wr_en=%b hold=%b done=%b err=%b addr=%h data=%h cnt=%0d, want all 0",
                     bus.rx_ready, bus.wr_en, core_hold, done, error, bus.wr_addr, bus.wr_data, loaded_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulse_start();
        send_byte(8'h80, 0);
        send_word(40'h00_0000_0042, 0);
        send_trailer();
        expect_done(cyc);
        checks++;
        if (log_data.size() != 1 || log_data[0] !== 39'h42) begin
            errors++;
            $display("FAIL reload_after_reset: writes=%0d, want 1 write of 42", log_data.size());
        end
    endtask

`ifdef INST_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        int d0;
        pulse_start();
        send_byte(8'h80, 0);
        send_word(40'h05_0403_0201, 0);
        send_byte(8'h01, 0);
        expect_done(cyc);
        checks++;
        if (cyc != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL cksum_good: cycles=%0d err=%b, want 1 0", cyc, error);
        end
        d0 = done_cnt;
        pulse_start();
        send_byte(8'h80, 0);
        send_word(40'h05_0403_0201, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (error !== 1'b1 || core_hold !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL cksum_bad: err=%b hold=%b dones=%0d, want 1 1 0", error, core_hold, done_cnt - d0);
        end
    endtask
`endif

    initial begin
        tb_xor = 8'h00;
        test_reset();
        test_single();
        test_full_load();
        test_bad_header();
        test_bit39();
        test_stall();
        test_reset_mid_load();
`ifdef INST_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
# inst_loader

Byte-stream instruction loader for the nucore pipeline; the writer side of the 64-entry, 39-bit instruction queue that the program counter reads. It accepts a framed byte stream from a host over a valid/ready handshake and assembles 5-byte little-endian words into 39-bit instructions. Each instruction is written into the queue's write port, and the core is held in reset while a program is being loaded.

## Interface
Parameters:
- DEPTH, 64, instruction queue entries; addresses are 6 bits.
- IW, 39, instruction width; bits 39 and above of each assembled 40-bit word must be zero.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or ERROR.
- rx_data  input  8  stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high on a clock edge.
- wr_en  output  1  instruction queue write strobe.
- wr_addr  output  6  queue write address.
- wr_data  output  39  queue write data.
- core_hold  output  1  drives the core's reset while a load is in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky framing error flag.
- loaded_count  output  7  number of instructions written in the current or last load (0..64).

## Operation
- States: IDLE, HEADER, BYTES, WRITE, CKSUM, DONE, ERROR.
- IDLE: rx_ready=0 and core_hold=0. start moves to HEADER, sets core_hold=1 and clears loaded_count, the byte index and the instruction index.
- HEADER: rx_ready=1. The accepted byte must have bits [7:6]=2'b10, otherwise go to ERROR. On a good byte, N = bits[5:0]+1 (range 1..64) and the state moves to BYTES.
- BYTES: rx_ready=1. Each accepted byte shifts into a 40-bit assembly register, least significant byte first.
  - On the 5th byte, if assembled bit 39 is 1, go to ERROR; no write occurs.
  - Otherwise go to WRITE.
- WRITE: rx_ready=0 and wr_en=1 for exactly one cycle, with wr_addr = instruction index and wr_data = assembled[38:0]. The instruction index and loaded_count increment.
  - If the index now equals N, go to CKSUM (when the macro is defined) or DONE.
  - Otherwise return to BYTES.
- DONE: done=1 for one cycle and core_hold=0 in the same cycle; next state is IDLE.
- ERROR: error=1, core_hold=1, rx_ready=0. start clears error and moves to HEADER. Queue contents already written are not rolled back.
- start in HEADER, BYTES, WRITE, CKSUM or DONE is ignored.
- rx_valid low stalls the load indefinitely. There is no timeout.
- Addresses run 0..N-1 with no wrap; N cannot exceed 64 by encoding.

## Timing
- Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0, error=0, loaded_count=0.
- Reset asserted mid-load aborts immediately: all outputs return to their reset values, any partially assembled word is discarded, and core_hold falls asynchronously.
- start to rx_ready high: 1 cycle.
- 5th byte of a word to wr_en: the edge that accepts the 5th byte enters WRITE, so wr_en is high in the following cycle. With no stalls, throughput is 6 cycles per instruction.
- Last WRITE to done: 1 cycle without the macro.
- All outputs are registered or decoded from the state register. rx_ready does not depend combinationally on rx_valid.

## Configuration
- INST_LOADER_CHECKSUM_EN defined:
  - After the Nth WRITE the loader enters CKSUM with rx_ready=1 and accepts one byte.
  - That byte must equal the XOR of all 5N payload bytes (the header byte is excluded).
  - Match goes to DONE; mismatch goes to ERROR with core_hold remaining 1.
- INST_LOADER_CHECKSUM_EN undefined: the CKSUM state and the checksum register are not built, and the last WRITE goes directly to DONE.

## Test plan
- Single instruction: start, header 8'h80, payload bytes 8'h01,8'h00,8'h00,8'h00,8'h40 -> one wr_en pulse with wr_addr=0 and wr_data=39'h4000000001, then done, core_hold=0, loaded_count=1.
- Full load: header 8'hBF followed by 320 bytes, where instruction i's bytes are {i,0,0,0,0} -> 64 writes at addresses 0..63 with wr_data=i, loaded_count=64, and no write beyond address 63.
- Bad header 8'h40 -> ERROR, error=1, core_hold=1, no wr_en. A following start and valid load then clears error.
- Bit 39 set: 5th byte 8'h80 -> ERROR with no write for that word; earlier words remain written.
- Stall and reset: with rx_valid toggled randomly, the write count still matches. Asserting reset_n=0 after the 3rd payload byte gives all outputs at reset values and core_hold=0.
- With INST_LOADER_CHECKSUM_EN: header 8'h80, payload 01,02,03,04,05, checksum 8'h01 -> done. The same stream with checksum 8'h00 -> error=1 and core_hold stays 1.
